// File: rtl/handshake_sender.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : handshake_sender                                           |
// | Description : Four-phase req/ack initiator with a synchronized ackIn.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module handshake_sender #(
  parameter int LEN    = 8,
  parameter int STAGES = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [LEN-1:0] dataIn,
  input  logic           validIn,
  output logic           readyOut,
  output logic [LEN-1:0] dataOut,
  output logic           reqOut,
  input  logic           ackIn,
  output logic           doneOut
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_REQ     = 2'd1;
  localparam logic [1:0] c_RELEASE = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_nextState;
  logic [STAGES-1:0] r_ackChain;
  logic              w_ackSync;
  logic              w_loadData;
  logic              w_reqNext;
  logic              w_doneNext;

  // ackIn is asynchronous to clk; only the last stage is ever observed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ackChain <= '0;
    end else begin
      r_ackChain <= {r_ackChain[STAGES-2:0], ackIn};
    end
  end

  assign w_ackSync = r_ackChain[STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_IDLE:    if (validIn)    w_nextState = c_REQ;
      c_REQ:     if (w_ackSync)  w_nextState = c_RELEASE;
      c_RELEASE: if (!w_ackSync) w_nextState = c_IDLE;
      default:                   w_nextState = c_IDLE;
    endcase
  end

  // Next values for the registered outputs; reqOut stays high through REQ.
  always_comb begin
    w_loadData = 1'b0;
    w_reqNext  = 1'b0;
    w_doneNext = 1'b0;
    case (r_state)
      c_IDLE: begin
        w_loadData = validIn;
        w_reqNext  = validIn;
      end
      c_REQ: begin
        w_reqNext  = !w_ackSync;
      end
      c_RELEASE: begin
        w_doneNext = !w_ackSync;
      end
      default: begin
        w_reqNext  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reqOut  <= 1'b0;
      doneOut <= 1'b0;
      dataOut <= '0;
    end else begin
      reqOut  <= w_reqNext;
      doneOut <= w_doneNext;
      if (w_loadData) begin
        dataOut <= dataIn;
      end
    end
  end

  assign readyOut = (r_state == c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_handshake_sender.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_handshake_sender                                        |
// | Description : Directed self-checking bench for handshake_sender.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_handshake_sender;

  localparam int c_LEN    = 8;
  localparam int c_STAGES = 2;

  logic             clk;
  logic             reset_n;
  logic [c_LEN-1:0] dataIn;
  logic             validIn;
  logic             readyOut;
  logic [c_LEN-1:0] dataOut;
  logic             reqOut;
  logic             ackIn;
  logic             doneOut;
  logic             tieAck;
  logic             ackDrv;

  int checks   = 0;
  int failures = 0;
  int doneCnt  = 0;

  // tieAck models a zero-delay consumer that echoes reqOut.
  assign ackIn = tieAck ? reqOut : ackDrv;

  handshake_sender #(.LEN(c_LEN), .STAGES(c_STAGES)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .dataIn   (dataIn),
    .validIn  (validIn),
    .readyOut (readyOut),
    .dataOut  (dataOut),
    .reqOut   (reqOut),
    .ackIn    (ackIn),
    .doneOut  (doneOut)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  always @(negedge clk) begin
    if (doneOut) doneCnt++;
  end

  typedef struct {
    logic             v;
    logic [c_LEN-1:0] d;
    logic             a;
    logic             rdy;
    logic             req;
    logic [c_LEN-1:0] dout;
    logic             done;
  } vec_t;

  vec_t vecs[14];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic a,
                              input logic rdy, input logic req, input logic [7:0] dout,
                              input logic done);
    vec_t r;
    r.v = v; r.d = d; r.a = a; r.rdy = rdy; r.req = req; r.dout = dout; r.done = done;
    return r;
  endfunction

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int doneBase;
    logic bad;

    // Ack rises before edge 3, reqOut falls after edge 5; ack falls before
    // edge 6, IDLE + done after edge 8. validIn during REQ/RELEASE ignored.
    vecs[0]  = mk(1, 8'h96, 0,  0, 1, 8'h96, 0);
    vecs[1]  = mk(1, 8'hFF, 0,  0, 1, 8'h96, 0);
    vecs[2]  = mk(0, 8'h00, 1,  0, 1, 8'h96, 0);
    vecs[3]  = mk(0, 8'h00, 1,  0, 1, 8'h96, 0);
    vecs[4]  = mk(0, 8'h00, 1,  0, 0, 8'h96, 0);
    vecs[5]  = mk(1, 8'hFF, 0,  0, 0, 8'h96, 0);
    vecs[6]  = mk(0, 8'h00, 0,  0, 0, 8'h96, 0);
    vecs[7]  = mk(0, 8'h00, 0,  1, 0, 8'h96, 1);
    vecs[8]  = mk(0, 8'h00, 0,  1, 0, 8'h96, 0);
    vecs[9]  = mk(0, 8'h00, 1,  1, 0, 8'h96, 0);
    vecs[10] = mk(0, 8'h00, 1,  1, 0, 8'h96, 0);
    vecs[11] = mk(0, 8'h00, 0,  1, 0, 8'h96, 0);
    vecs[12] = mk(0, 8'h00, 0,  1, 0, 8'h96, 0);
    vecs[13] = mk(0, 8'h00, 0,  1, 0, 8'h96, 0);

    // Reset with active-looking inputs
    reset_n = 1'b0; validIn = 1'b1; dataIn = 8'hA5; ackDrv = 1'b1; tieAck = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req",  reqOut,  0);
    chk("rst_data", dataOut, 8'h00);
    chk("rst_done", doneOut, 0);
    validIn = 1'b0; ackDrv = 1'b0;
    reset_n = 1'b1;
    step();
    chk("rst_ready", readyOut, 1);
    chk("rst_req_after", reqOut, 0);

    // Zero-delay consumer
    tieAck = 1'b1; validIn = 1'b1; dataIn = 8'h3C;
    step();
    validIn = 1'b0;
    chk("tie_data", dataOut, 8'h3C);
    chk("tie_req0", reqOut, 1);
    chk("tie_rdy0", readyOut, 0);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("tie_req%0d", k), reqOut, (k <= 2) ? 1 : 0);
      chk($sformatf("tie_done%0d", k), doneOut, (k == 6) ? 1 : 0);
      chk($sformatf("tie_rdy%0d", k), readyOut, (k == 6) ? 1 : 0);
    end
    step();
    chk("tie_done_clear", doneOut, 0);
    tieAck = 1'b0; ackDrv = 1'b0;

    // Table-driven manual-ack transfer
    for (int i = 0; i < 14; i++) begin
      validIn = vecs[i].v; dataIn = vecs[i].d; ackDrv = vecs[i].a;
      step();
      chk($sformatf("vec%0d_rdy", i),  readyOut, vecs[i].rdy);
      chk($sformatf("vec%0d_req", i),  reqOut,   vecs[i].req);
      chk($sformatf("vec%0d_data", i), dataOut,  vecs[i].dout);
      chk($sformatf("vec%0d_done", i), doneOut,  vecs[i].done);
    end
    validIn = 1'b0; ackDrv = 1'b0;
    step();

    // Slow consumer
    validIn = 1'b1; dataIn = 8'h3C;
    step();
    validIn = 1'b0;
    chk("slow_req_rise", reqOut, 1);
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (reqOut !== 1'b1 || dataOut !== 8'h3C || doneOut !== 1'b0) bad = 1'b1;
    end
    chk("slow_hold_req", bad, 0);
    ackDrv = 1'b1;
    n = 0;
    bad = 1'b0;
    do begin
      step();
      n++;
      if (doneOut !== 1'b0 || dataOut !== 8'h3C) bad = 1'b1;
    end while (reqOut !== 1'b0 && n < 20);
    chk("slow_req_fall_edges", n, c_STAGES + 1);
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (reqOut !== 1'b0 || dataOut !== 8'h3C || doneOut !== 1'b0 || readyOut !== 1'b0) bad = 1'b1;
    end
    chk("slow_hold_release", bad, 0);
    ackDrv = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (doneOut !== 1'b1 && n < 20);
    chk("slow_done_edges", n, c_STAGES + 1);
    chk("slow_ready", readyOut, 1);
    chk("slow_data", dataOut, 8'h3C);
    step();

    // Back-to-back with zero-delay consumer
    doneBase = doneCnt;
    tieAck = 1'b1; validIn = 1'b1; dataIn = 8'h11;
    step();
    chk("b2b_data1", dataOut, 8'h11);
    dataIn = 8'h22;
    repeat (5) step();
    chk("b2b_nodone_early", doneOut, 0);
    step();
    chk("b2b_done1", doneOut, 1);
    chk("b2b_rdy_at_done", readyOut, 1);
    chk("b2b_data_hold", dataOut, 8'h11);
    step();
    validIn = 1'b0;
    chk("b2b_data2", dataOut, 8'h22);
    chk("b2b_req2", reqOut, 1);
    chk("b2b_rdy2", readyOut, 0);
    repeat (6) step();
    chk("b2b_done2", doneOut, 1);
    step();
    chk("b2b_done_count", doneCnt - doneBase, 2);
    tieAck = 1'b0; ackDrv = 1'b0;

    // Reset mid-transfer
    validIn = 1'b1; dataIn = 8'h77;
    step();
    validIn = 1'b0;
    step();
    chk("mid_in_req", reqOut, 1);
    doneBase = doneCnt;
    #0.5;
    reset_n = 1'b0;
    #0.2;
    chk("mid_req_async", reqOut, 0);
    chk("mid_data_async", dataOut, 8'h00);
    chk("mid_done_async", doneOut, 0);
    @(negedge clk);
    step();
    reset_n = 1'b1;
    repeat (3) step();
    chk("mid_no_done", doneCnt - doneBase, 0);
    chk("mid_ready", readyOut, 1);
    tieAck = 1'b1; validIn = 1'b1; dataIn = 8'h5A;
    step();
    validIn = 1'b0;
    chk("mid_new_data", dataOut, 8'h5A);
    repeat (6) step();
    chk("mid_new_done", doneOut, 1);
    step();
    chk("mid_new_done_clear", doneOut, 0);
    chk("mid_new_ready", readyOut, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
